muldiv_unit: RTL and testbench

- Multi-cycle integer multiply/divide unit for the pipelined MIPS core. It executes the MULT, MULTU, DIV and DIVU R-type operations that the ALU decoder flags.
- Results go into architectural HI/LO registers. The unit exposes busy/done so the hazard unit can stall MFHI/MFLO and any new mul/div while an operation is in flight.
- Width is parametrised, so the same block serves the 32-bit core and narrower test configurations.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_signfix.sv | 12 +
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the multi-cycle multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  function automatic logic is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: magnitude on operand entry, sign restore on results.
module muldiv_signfix #(
  parameter int unsigned W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 multi-cycle MULT/MULTU/DIV/DIVU unit writing the architectural HI/LO registers.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_acc;    // partial product upper half / partial remainder
  logic [WIDTH-1:0] r_q;      // multiplier / dividend-quotient shift register
  logic [WIDTH-1:0] r_mcand;  // multiplicand / divisor magnitude
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic             r_done;

  md_op_t             w_op;
  logic               w_sgn;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_step_acc;
  logic [WIDTH-1:0]   w_step_q;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH+1:0]   w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_op    = md_op_t'(op);
  assign w_sgn   = is_signed(w_op);
  assign w_a_neg = w_sgn & a[WIDTH-1];
  assign w_b_neg = w_sgn & b[WIDTH-1];

  muldiv_signfix #(.W(WIDTH)) u_mag_a (.i_neg(w_a_neg), .i_val(a), .o_val(w_a_mag));
  muldiv_signfix #(.W(WIDTH)) u_mag_b (.i_neg(w_b_neg), .i_val(b), .o_val(w_b_mag));

  always_comb begin
    w_step_acc = r_acc;
    w_step_q   = r_q;
    w_sum      = '0;
    w_rem_sh   = '0;
    w_diff     = '0;
    if (r_div) begin
      // Restoring step: keep the shifted remainder if the trial subtract borrows.
      w_rem_sh = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
      w_diff   = {1'b0, w_rem_sh} - {2'b00, r_mcand};
      if (w_diff[WIDTH+1]) begin
        w_step_acc = w_rem_sh;
        w_step_q   = {r_q[WIDTH-2:0], 1'b0};
      end else begin
        w_step_acc = w_diff[WIDTH:0];
        w_step_q   = {r_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      w_sum      = r_q[0] ? ({1'b0, r_acc[WIDTH-1:0]} + {1'b0, r_mcand}) : r_acc;
      w_step_acc = {1'b0, w_sum[WIDTH:1]};
      w_step_q   = {w_sum[0], r_q[WIDTH-1:1]};
    end
  end

  muldiv_signfix #(.W(2*WIDTH)) u_fix_p (
    .i_neg(r_neg_q),
    .i_val({r_acc[WIDTH-1:0], r_q}),
    .o_val(w_prod)
  );
  muldiv_signfix #(.W(WIDTH)) u_fix_q (.i_neg(r_neg_q), .i_val(r_q), .o_val(w_quo));
  muldiv_signfix #(.W(WIDTH)) u_fix_r (
    .i_neg(r_neg_r),
    .i_val(r_acc[WIDTH-1:0]),
    .o_val(w_rem)
  );

  // Most-negative / -1 needs no special case: the unsigned quotient magnitude is already 2^(W-1).
  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_div) begin
      if (r_dz) begin
        w_res_hi = r_a;
        w_res_lo = '1;
      end else begin
        w_res_hi = w_rem;
        w_res_lo = w_quo;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_mcand <= '0;
      r_a     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (wr_hi) r_hi <= wdata;
          if (wr_lo) r_lo <= wdata;
          if (start && !flush) begin
            r_div   <= is_div(w_op);
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dz    <= is_div(w_op) && (b == '0);
            r_a     <= a;
            r_acc   <= '0;
            r_q     <= is_div(w_op) ? w_a_mag : w_b_mag;
            r_mcand <= is_div(w_op) ? w_b_mag : w_a_mag;
            r_cnt   <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            r_state <= IDLE;
          end else begin
            r_acc <= w_step_acc;
            r_q   <= w_step_q;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) r_state <= FIX;
          end
        end
        FIX: begin
          r_state <= IDLE;
          if (!flush) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops vs. an arithmetic model.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         wr_hi;
  logic         wr_lo;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int           n_chk = 0;
  int           n_err = 0;
  logic [W-1:0] e_hi;
  logic [W-1:0] e_lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .flush(flush),
    .wr_hi(wr_hi),
    .wr_lo(wr_lo),
    .wdata(wdata),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain SV arithmetic; returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint          sp;
    longint unsigned up;
    int              sq;
    int              sr;
    case (o)
      2'b00: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        return sp;
      end
      2'b01: begin
        up = {32'b0, x} * {32'b0, y};
        return up;
      end
      2'b10: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {sr, sq};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Called at posedge+1; drives start so it is sampled on the next edge, returns at that edge+1.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // Called at start-edge+1; returns at done-edge+1 (the done cycle).
  task automatic wait_res(input logic [63:0] r, input string tag);
    int n;
    int dn;
    n  = 0;
    dn = 0;
    while (busy && n < 100) begin
      if (done) dn++;
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'd33);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".early_done"}, 32'(dn), 32'd0);
    chk({tag, ".hi"}, hi, r[63:32]);
    chk({tag, ".lo"}, lo, r[31:0]);
    e_hi = r[63:32];
    e_lo = r[31:0];
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input string tag);
    logic [63:0] r;
    r = model(o, x, y);
    issue(o, x, y);
    wait_res(r, tag);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    flush = 1'b0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.hi", hi, 32'h0);
    chk("rst.lo", lo, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, "multu_max");
    @(posedge clk);
    #1;
    chk("multu_max.done_drop", 32'(done), 32'd0);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_b2b");

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run_op(2'b11, 32'd7, 32'd2, "divu");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'b11, 32'd5, 32'd0, "divu_dz");
    run_op(2'b10, 32'd5, 32'd0, "div_dz");

    // MTLO in the done cycle
    wr_lo = 1'b1;
    wdata = 32'h0000_5A5A;
    @(posedge clk);
    #1;
    wr_lo = 1'b0;
    e_lo  = 32'h0000_5A5A;
    chk("wrlo_done_cycle", lo, e_lo);

    // Preload HI, start DIVU, ignored start+MTLO at cycle 5, flush at cycle 10
    wr_hi = 1'b1;
    wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    wr_hi = 1'b0;
    e_hi  = 32'hA5A5_A5A5;
    chk("wrhi_preload", hi, e_hi);
    issue(2'b11, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    op    = 2'b00;
    wr_lo = 1'b1;
    wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    wr_lo = 1'b0;
    chk("busy_wr.lo", lo, e_lo);
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush.busy", 32'(busy), 32'd0);
    chk("flush.done0", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    chk("flush.done1", 32'(done), 32'd0);
    chk("flush.hi", hi, e_hi);
    chk("flush.lo", lo, e_lo);

    // Flush in IDLE overrides start
    start = 1'b1;
    flush = 1'b1;
    op    = 2'b01;
    a     = 32'd3;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    chk("idle_flush.busy", 32'(busy), 32'd0);

    // Flush during FIX: no result, no done
    issue(2'b01, 32'd11, 32'd13);
    repeat (32) @(posedge clk);
    #1;
    chk("fix.busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("fix_flush.busy", 32'(busy), 32'd0);
    chk("fix_flush.done", 32'(done), 32'd0);
    chk("fix_flush.hi", hi, e_hi);
    chk("fix_flush.lo", lo, e_lo);

    // MTHI together with start: write lands, result later overwrites
    wr_hi = 1'b1;
    wdata = 32'h1111_2222;
    issue(2'b01, 32'd9, 32'd9);
    chk("wr_start.hi", hi, 32'h1111_2222);
    wait_res(model(2'b01, 32'd9, 32'd9), "wr_start");

    // Async reset mid-CALC
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst.busy", 32'(busy), 32'd0);
    chk("mid_rst.done", 32'(done), 32'd0);
    chk("mid_rst.hi", hi, 32'h0);
    chk("mid_rst.lo", lo, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_op(2'b01, 32'd6, 32'd7, "post_rst");

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
